en_counter: RTL and testbench

- Parameterised free-running binary up-counter with a synchronous enable. Provides a simple counter primitive for bring-up and smoke-test flows.
- Counts clock edges while enabled and holds its value otherwise.
- Wraps modulo 2^WIDTH.
- Status outputs flag the terminal value and the rollover event.

---
 rtl/counter_pkg.sv | 15 +
 rtl/en_counter.sv | 33 +++
 tb/tb_en_counter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the enable counter: default width and the all-ones
// decode used by both the design and its scoreboard.
package counter_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 8;

    // True when the low `width` bits of value are all ones (width in 1..64).
    function automatic logic is_all_ones(input logic [63:0] value,
                                         input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value & mask) == mask;
    endfunction

endpackage

// File: rtl/en_counter.sv
// Free-running up-counter with synchronous enable, terminal-value decode and
// a registered one-cycle rollover pulse.
module en_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             wrap
);

    assign at_max = is_all_ones(64'(count), WIDTH);

    // NOTE: reset is sampled inside the clocked process, so it is synchronous
    // and overrides en; all state is assigned with <= so every register sees
    // the pre-edge values of count and at_max.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= en && at_max;
            if (en) begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_en_counter.sv
// Scoreboard bench for en_counter: drives WIDTH=8 and WIDTH=1 instances with
// the same directed stimulus and compares every cycle against a small model.
module tb_en_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] count8;
    logic       at_max8;
    logic       wrap8;
    logic [0:0] count1;
    logic       at_max1;
    logic       wrap1;

    en_counter #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .count  (count8),
        .at_max (at_max8),
        .wrap   (wrap8)
    );

    en_counter #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .count  (count1),
        .at_max (at_max1),
        .wrap   (wrap1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c8;
        logic       a8;
        logic       w8;
        logic       c1;
        logic       a1;
        logic       w1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    logic [7:0] m8 = '0;
    logic       mw8 = 1'b0;
    logic       m1 = 1'b0;
    logic       mw1 = 1'b0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Apply one edge of stimulus, advance the model, queue the expectation.
    task automatic step(input logic e, input logic r);
        exp_t x;
        en    = e;
        rst_n = r;
        @(posedge clk);
        #1;
        if (!r) begin
            m8 = '0; mw8 = 1'b0;
            m1 = 1'b0; mw1 = 1'b0;
        end else if (e) begin
            mw8 = (m8 == 8'hFF);
            m8  = m8 + 8'd1;
            mw1 = m1;
            m1  = ~m1;
        end else begin
            mw8 = 1'b0;
            mw1 = 1'b0;
        end
        x.c8 = m8;
        x.a8 = is_all_ones(64'(m8), 8);
        x.w8 = mw8;
        x.c1 = m1;
        x.a1 = is_all_ones(64'(m1), 1);
        x.w1 = mw1;
        exp_q.push_back(x);
    endtask

    task automatic run(input int n, input logic e, input logic r);
        for (int i = 0; i < n; i++) step(e, r);
    endtask

    // Monitor: compares the DUT outputs on the falling edge after each step.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("count8", 64'(count8), 64'(x.c8));
                check("at_max8", 64'(at_max8), 64'(x.a8));
                check("wrap8", 64'(wrap8), 64'(x.w8));
                check("count1", 64'(count1), 64'(x.c1));
                check("at_max1", 64'(at_max1), 64'(x.a1));
                check("wrap1", 64'(wrap1), 64'(x.w1));
            end
        end
    end

    initial begin : stimulus
        int drain;

        // Reset hold, then idle.
        run(10, 1'b0, 1'b0);
        check("reset_count8", 64'(count8), 64'd0);
        run(5, 1'b0, 1'b1);
        check("idle_count8", 64'(count8), 64'd0);

        // Basic count: 50 enabled edges.
        run(50, 1'b1, 1'b1);
        check("count50", 64'(count8), 64'h32);
        check("count50_w1", 64'(count1), 64'd0);

        // Rollover from 0.
        run(1, 1'b1, 1'b0);
        run(255, 1'b1, 1'b1);
        check("at_255", 64'(count8), 64'd255);
        check("at_max_255", 64'(at_max8), 64'd1);
        run(1, 1'b1, 1'b1);
        check("roll_count", 64'(count8), 64'd0);
        check("roll_wrap", 64'(wrap8), 64'd1);
        run(1, 1'b1, 1'b1);
        check("post_roll_count", 64'(count8), 64'd1);
        check("post_roll_wrap", 64'(wrap8), 64'd0);

        // Enable dropped at all-ones.
        run(1, 1'b0, 1'b0);
        run(255, 1'b1, 1'b1);
        run(3, 1'b0, 1'b1);
        check("hold_max_count", 64'(count8), 64'd255);
        check("hold_max_at_max", 64'(at_max8), 64'd1);
        check("hold_max_wrap", 64'(wrap8), 64'd0);

        // Enable gating then mid-run reset with en high.
        run(1, 1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("gated_count", 64'(count8), 64'd3);
        check("gated_count1", 64'(count1), 64'd1);
        step(1'b1, 1'b0);
        check("mid_reset_count", 64'(count8), 64'd0);
        run(2, 1'b1, 1'b1);
        check("resume_count", 64'(count8), 64'd2);

        // Narrow width: toggle sequence and wrap on each 1->0.
        run(1, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1);
            check("w1_toggle", 64'(count1), 64'(i % 2));
            check("w1_wrap", 64'(wrap1), 64'((i % 2) == 0));
        end

        // Let the monitor drain the queue, bounded.
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            #1;
            drain++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
